// File: rtl/id_stream_gen_pkg.sv
// Shared constants for the identifier stream generator and its recogniser partner.
package id_stream_gen_pkg;

  // ASCII anchors used by both the char selector and the recogniser range checks
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;

  // Last index before wrapping back to 'a'/'A' or '0'
  localparam logic [4:0] LETTER_WRAP = 5'd25;
  localparam logic [4:0] DIGIT_WRAP  = 5'd9;

  // FSM encoding, also used as the phase select of the char selector
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LETTERS = 2'd1;
  localparam logic [1:0] ST_DIGITS  = 2'd2;
  localparam logic [1:0] ST_SEP     = 2'd3;

  // Wrapping increment of the shared letter/digit index
  function automatic logic [4:0] idx_inc(input logic [4:0] idx, input logic [4:0] lim);
    return (idx == lim) ? 5'd0 : idx + 5'd1;
  endfunction

endpackage

// File: rtl/id_stream_gen_char_sel.sv
// Combinational phase/index/case -> ASCII mapping.
module id_char_sel
  import id_stream_gen_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = ASCII_SPACE
) (
  input  logic [1:0] phase_i,
  input  logic [4:0] idx_i,
  input  logic       upper_i,
  output logic [7:0] char_o
);

  // Letters and digits are offsets from their ASCII base; idle drives NUL
  always_comb begin
    char_o = 8'h00;
    case (phase_i)
      ST_LETTERS: char_o = (upper_i ? ASCII_UPPER_A : ASCII_LOWER_A) + {3'b000, idx_i};
      ST_DIGITS:  char_o = ASCII_ZERO + {3'b000, idx_i};
      ST_SEP:     char_o = SEP_CHAR;
      default:    char_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/id_stream_gen.sv
// Identifier-shaped burst generator: letters, digits, one separator, with the
// golden recogniser output alongside every char. Valid/ready on the char side.
module id_stream_gen
  import id_stream_gen_pkg::*;
#(
  parameter int         MAX_LEN_W = 4,
  parameter logic [7:0] SEP_CHAR  = ASCII_SPACE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MAX_LEN_W-1:0] n_letters,
  input  logic [MAX_LEN_W-1:0] n_digits,
  input  logic                 upper,
  input  logic                 char_ready,
  output logic [7:0]           char_out,
  output logic                 char_valid,
  output logic                 id_exp,
  output logic                 busy,
  output logic                 done
);

  localparam logic [MAX_LEN_W-1:0] CNT_ONE = MAX_LEN_W'(1);

  logic [1:0]           state_q, state_d;
  logic [MAX_LEN_W-1:0] let_cnt_q, let_cnt_d;
  logic [MAX_LEN_W-1:0] dig_cnt_q, dig_cnt_d;
  logic [4:0]           idx_q, idx_d;
  logic                 upper_q, upper_d;
  logic                 has_let_q, has_let_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [7:0]           char_out_q, char_out_d;
  logic                 char_valid_q, char_valid_d;
  logic                 id_exp_q, id_exp_d;
  logic                 fire;

  assign fire = char_valid_q & char_ready;

  // Next-state: phase sequencing, remaining-count and index bookkeeping
  always_comb begin
    state_d   = state_q;
    let_cnt_d = let_cnt_q;
    dig_cnt_d = dig_cnt_q;
    idx_d     = idx_q;
    upper_d   = upper_q;
    has_let_d = has_let_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          let_cnt_d = n_letters;
          dig_cnt_d = n_digits;
          upper_d   = upper;
          has_let_d = |n_letters;
          idx_d     = 5'd0;
          busy_d    = 1'b1;
          if (|n_letters)     state_d = ST_LETTERS;
          else if (|n_digits) state_d = ST_DIGITS;
          else                state_d = ST_SEP;
        end
      end
      ST_LETTERS: begin
        if (fire) begin
          let_cnt_d = let_cnt_q - CNT_ONE;
          idx_d     = idx_inc(idx_q, LETTER_WRAP);
          if (let_cnt_q == CNT_ONE) begin
            idx_d   = 5'd0;
            state_d = (|dig_cnt_q) ? ST_DIGITS : ST_SEP;
          end
        end
      end
      ST_DIGITS: begin
        if (fire) begin
          dig_cnt_d = dig_cnt_q - CNT_ONE;
          idx_d     = idx_inc(idx_q, DIGIT_WRAP);
          if (dig_cnt_q == CNT_ONE) begin
            idx_d   = 5'd0;
            state_d = ST_SEP;
          end
        end
      end
      default: begin
        if (fire) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // Outputs are registered from the next-state view so the char appears the
  // cycle after the decision and holds while the sink stalls
  id_char_sel #(.SEP_CHAR(SEP_CHAR)) u_char_sel (
    .phase_i (state_d),
    .idx_i   (idx_d),
    .upper_i (upper_d),
    .char_o  (char_out_d)
  );

  // Valid and golden id follow the upcoming phase
  always_comb begin
    char_valid_d = (state_d != ST_IDLE);
    id_exp_d     = (state_d == ST_DIGITS) && has_let_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      let_cnt_q    <= '0;
      dig_cnt_q    <= '0;
      idx_q        <= 5'd0;
      upper_q      <= 1'b0;
      has_let_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      char_out_q   <= 8'h00;
      char_valid_q <= 1'b0;
      id_exp_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      let_cnt_q    <= let_cnt_d;
      dig_cnt_q    <= dig_cnt_d;
      idx_q        <= idx_d;
      upper_q      <= upper_d;
      has_let_q    <= has_let_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      id_exp_q     <= id_exp_d;
    end
  end

  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;
  assign id_exp     = id_exp_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_id_stream_gen.sv
// Bench for id_stream_gen: fixed vector table, hand-written stall/reset/start
// sequences, random bursts with random ready against a burst scoreboard and a
// behavioural identifier recogniser.
module tb_id_stream_gen;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] n_letters, n_digits;
  logic         upper, char_ready;
  logic [7:0]   char_out;
  logic         char_valid, id_exp, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  id_stream_gen #(.MAX_LEN_W(W), .SEP_CHAR(8'h20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_letters(n_letters), .n_digits(n_digits),
    .upper(upper), .char_ready(char_ready), .char_out(char_out), .char_valid(char_valid),
    .id_exp(id_exp), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned q_chr[$];
  bit           q_id[$];
  byte unsigned cap_chr[$];
  bit           cap_id[$];
  bit           m_busy = 0, m_done = 0;
  int           rec_st = 0;  // 0 token start, 1 letters seen, 2 letters+digits, 3 not an id

  function automatic bit is_alpha(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5a) || (c >= 8'h61 && c <= 8'h7a);
  endfunction
  function automatic bit is_digit(input logic [7:0] c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction
  function automatic bit rec_out(input int st, input logic [7:0] c);
    return is_digit(c) && (st == 1 || st == 2);
  endfunction
  function automatic int rec_next(input int st, input logic [7:0] c);
    if (!is_alpha(c) && !is_digit(c)) return 0;
    if (is_alpha(c)) return (st <= 1) ? 1 : 3;
    return (st == 1 || st == 2) ? 2 : 3;
  endfunction

  task automatic push_burst(input int nl, input int nd, input bit up);
    for (int i = 0; i < nl; i++) begin
      q_chr.push_back(8'((up ? 65 : 97) + (i % 26)));
      q_id.push_back(1'b0);
    end
    for (int i = 0; i < nd; i++) begin
      q_chr.push_back(8'(48 + (i % 10)));
      q_id.push_back(nl != 0);
    end
    q_chr.push_back(8'h20);
    q_id.push_back(1'b0);
  endtask

  // Scoreboard at the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q_chr.delete(); q_id.delete();
      m_busy = 0; m_done = 0; rec_st = 0;
      chk("rst_valid", {7'd0, char_valid}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
    end else begin
      chk("busy", {7'd0, busy}, {7'd0, m_busy});
      chk("done", {7'd0, done}, {7'd0, m_done});
      chk("valid", {7'd0, char_valid}, {7'd0, m_busy});
      if (m_busy && q_chr.size() > 0) begin
        chk("char", char_out, q_chr[0]);
        chk("id_exp", {7'd0, id_exp}, {7'd0, q_id[0]});
        chk("recog", {7'd0, id_exp}, {7'd0, rec_out(rec_st, char_out)});
      end
      m_done = 0;
      if (m_busy && char_ready) begin
        cap_chr.push_back(char_out);
        cap_id.push_back(id_exp);
        if (q_chr.size() > 0) begin
          rec_st = rec_next(rec_st, q_chr[0]);
          void'(q_chr.pop_front());
          void'(q_id.pop_front());
        end
        if (q_chr.size() == 0) begin m_busy = 0; m_done = 1; end
      end else if (!m_busy && start) begin
        push_burst(int'(n_letters), int'(n_digits), upper);
        m_busy = 1;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic run_burst(input int nl, input int nd, input bit up, input bit rnd, output int cyc);
    @(posedge clk); #1;
    n_letters = W'(nl); n_digits = W'(nd); upper = up; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      if (rnd) char_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: no done after %0d cycles, expected within 3000", cyc);
    end
  endtask

  task automatic chk_cap(input string nm, input string s, input string m);
    chk({nm, "_len"}, 8'(cap_chr.size()), 8'(s.len()));
    for (int i = 0; i < s.len() && i < cap_chr.size(); i++) begin
      chk({nm, "_chr"}, cap_chr[i], s.getc(i));
      chk({nm, "_id"}, {7'd0, cap_id[i]}, {7'd0, m.getc(i) == 8'h31});
    end
  endtask

  typedef struct {
    int    nl;
    int    nd;
    bit    up;
    string s;
    string m;
  } vec_t;

  vec_t vecs[4];
  int   cyc;

  initial begin
    vecs[0] = '{2, 3, 1'b0, "ab012 ", "001110"};
    vecs[1] = '{28, 12, 1'b1, "ABCDEFGHIJKLMNOPQRSTUVWXYZAB012345678901 ",
                "00000000000000000000000000001111111111110"};
    vecs[2] = '{0, 2, 1'b0, "01 ", "000"};
    vecs[3] = '{0, 0, 1'b1, " ", "0"};

    rst_n = 1'b0; start = 1'b0; n_letters = '0; n_digits = '0; upper = 1'b0; char_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_char", char_out, 8'h00);
    chk("reset_id", {7'd0, id_exp}, 8'd0);
    chk("reset_done", {7'd0, done}, 8'd0);
    rst_n = 1'b1;
    char_ready = 1'b1;

    // Table: full-rate bursts, L+D+1 beats back to back
    for (int v = 0; v < 4; v++) begin
      cap_chr.delete(); cap_id.delete();
      run_burst(vecs[v].nl, vecs[v].nd, vecs[v].up, 1'b0, cyc);
      chk($sformatf("vec%0d_cycles", v), 8'(cyc), 8'(vecs[v].nl + vecs[v].nd + 1));
      chk_cap($sformatf("vec%0d", v), vecs[v].s, vecs[v].m);
    end

    // Stall three cycles while 'b' is presented
    cap_chr.delete(); cap_id.delete();
    @(posedge clk); #1;
    n_letters = 5'd2; n_digits = 5'd3; upper = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    char_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_hold", char_out, 8'h62);
      chk("stall_valid", {7'd0, char_valid}, 8'd1);
    end
    char_ready = 1'b1;
    cyc = 0;
    while (!done && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk_cap("stall", "ab012 ", "001110");

    // start mid-burst must be ignored
    cap_chr.delete(); cap_id.delete();
    @(posedge clk); #1;
    n_letters = 5'd3; n_digits = 5'd2; upper = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_letters = 5'd1; n_digits = 5'd1; upper = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 50) begin @(posedge clk); #1; cyc++; end
    repeat (3) @(posedge clk);
    #1;
    chk_cap("midstart", "abc01 ", "000110");

    // Async reset mid-burst, then a fresh burst starts from 'a'
    @(posedge clk); #1;
    n_letters = 5'd4; n_digits = 5'd4; upper = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {7'd0, char_valid}, 8'd0);
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    chk("midrst_char", char_out, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cap_chr.delete(); cap_id.delete();
    run_burst(2, 1, 1'b0, 1'b0, cyc);
    chk_cap("postrst", "ab0 ", "0010");

    // Random counts, case and ready; scoreboard and recogniser check every cycle
    for (int b = 0; b < 40; b++) begin
      run_burst(int'($urandom_range(0, 31)), int'($urandom_range(0, 14)),
                1'($urandom_range(0, 1)), 1'b1, cyc);
    end
    char_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
